// File: rtl/if_id_latch.sv
// IF/ID pipeline latch with stall/flush/HALT handling and a combinational PC enable.
// Optional stall-cycle counter output is enabled by defining IFID_STALL_CNT_EN.
module if_id_latch #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_plus2_in,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        halt_out,
    output logic        pc_en
`ifdef IFID_STALL_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    localparam int unsigned W       = 16;
    localparam int unsigned OPC_W   = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALLED = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_instr;
    logic [W-1:0]   r_pc2;
    logic           r_valid;
    logic           r_halt;
    logic [W-1:0]   w_instr_nxt;
    logic [W-1:0]   w_pc2_nxt;
    logic           w_valid_nxt;
    logic           w_halt_nxt;
    logic           w_load;
    logic           w_load_halt;

    // A HALT opcode is any word whose top five bits are zero.
    assign w_load      = ~flush & ~stall & (r_state != HALTED);
    assign w_load_halt = w_load & (instr_in[W-1 -: OPC_W] == OPC_W'(0));

    // Next-state and next-payload selection: flush > stall > load.
    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = r_instr;
        w_pc2_nxt   = r_pc2;
        w_valid_nxt = r_valid;
        w_halt_nxt  = r_halt;
        if (flush) begin
            w_state_nxt = RUN;
            w_instr_nxt = NOP_INSTR;
            w_pc2_nxt   = W'(0);
            w_valid_nxt = 1'b0;
            w_halt_nxt  = 1'b0;
        end else if (stall) begin
            if (r_state != HALTED) begin
                w_state_nxt = STALLED;
            end
        end else if (w_load) begin
            w_instr_nxt = instr_in;
            w_pc2_nxt   = pc_plus2_in;
            w_valid_nxt = 1'b1;
            w_halt_nxt  = w_load_halt;
            w_state_nxt = w_load_halt ? HALTED : RUN;
        end
    end

    // State and payload registers; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_instr <= NOP_INSTR;
            r_pc2   <= W'(0);
            r_valid <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_instr <= w_instr_nxt;
            r_pc2   <= w_pc2_nxt;
            r_valid <= w_valid_nxt;
            r_halt  <= w_halt_nxt;
        end
    end

    // PC is frozen on stall, while halted, and in the cycle a HALT is captured.
    assign pc_en = rst | ~(stall | (r_state == HALTED) | w_load_halt);

    assign instr_out    = r_instr;
    assign pc_plus2_out = r_pc2;
    assign valid_out    = r_valid;
    assign halt_out     = r_halt;

`ifdef IFID_STALL_CNT_EN
    logic [W-1:0] r_stall_cnt;

    // Saturating count of cycles spent under a non-flushed stall request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= W'(0);
        end else if (stall && !flush && (r_stall_cnt != {W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + W'(1);
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: doc/if_id_latch.md
IF_ID_LATCH -- requirements
Module: if_id_latch

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 16'h0800, meaning the encoding injected as a bubble.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-004 The block SHALL have port instr_in, input, 16, instruction word from the fetch stage.
REQ-005 The block SHALL have port pc_plus2_in, input, 16, PC+2 from the fetch stage.
REQ-006 The block SHALL have port stall, input, 1, hazard-unit hold request.
REQ-007 The block SHALL have port flush, input, 1, branch/jump squash request.
REQ-008 The block SHALL have port instr_out, output, 16, registered instruction to decode.
REQ-009 The block SHALL have port pc_plus2_out, output, 16, registered PC+2 to decode.
REQ-010 The block SHALL have port valid_out, output, 1, high when instr_out is a real fetched instruction.
REQ-011 The block SHALL have port halt_out, output, 1, high while a HALT is held.
REQ-012 The block SHALL have port pc_en, output, 1, combinational enable for the upstream PC register.

Function
REQ-013 State machine SHALL have states RUN, STALLED, HALTED; encoding implementation-defined.
REQ-014 Per-cycle priority SHALL be rst > flush > stall > load.
REQ-015 Load (RUN or STALLED, no flush, no stall): next cycle instr_out=instr_in, pc_plus2_out=pc_plus2_in, valid_out=1; state -> RUN.
REQ-016 Load with instr_in[15:11]==5'b00000 (HALT) SHALL capture as REQ-015, set halt_out=1, state -> HALTED.
REQ-017 Stall (no flush): all outputs SHALL hold; state -> STALLED (from RUN/STALLED), HALTED stays HALTED.
REQ-018 Flush: next cycle instr_out=NOP_INSTR, pc_plus2_out=0, valid_out=0, halt_out=0, state -> RUN, from any state, regardless of stall.
REQ-019 In HALTED, loads SHALL be ignored; outputs hold until flush or rst.
REQ-020 pc_en SHALL equal ~(stall | state==HALTED | next-load-is-HALT), i.e. low in the same cycle a HALT is captured, so the PC does not advance past a HALT.
REQ-021 Load latency SHALL be exactly one cycle; no combinational path from instr_in to instr_out.
REQ-022 Stall and flush asserted together SHALL behave as flush (REQ-018).

Reset
REQ-023 With rst high at a clock edge: instr_out=NOP_INSTR, pc_plus2_out=16'h0000, valid_out=0, halt_out=0, state=RUN, irrespective of stall/flush/state.
REQ-024 Reset asserted mid-stall or in HALTED SHALL return to RUN in one cycle; first load possible on the cycle after rst deasserts.
REQ-025 pc_en SHALL be 1 while rst is high.

Configuration
REQ-026 Macro IFID_STALL_CNT_EN SHALL, when defined, add output stall_cycles[15:0]: increments once per cycle with stall=1, flush=0, rst=0; saturates at 16'hFFFF; cleared to 0 by rst; unaffected by flush.
REQ-027 Without IFID_STALL_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 rst=1 two cycles with instr_in=16'h4123 -> instr_out=16'h0800, valid_out=0, pc_plus2_out=0, pc_en=1.
REQ-029 Load instr_in=16'h4123, pc_plus2_in=16'h0002 -> next cycle instr_out=16'h4123, pc_plus2_out=16'h0002, valid_out=1.
REQ-030 After load of 16'h4123, stall=1 for 3 cycles with instr_in=16'hB000 -> instr_out stays 16'h4123, pc_en=0; stall_cycles=3 if enabled; release -> 16'hB000 captured.
REQ-031 stall=1 and flush=1 same cycle -> next cycle instr_out=16'h0800, valid_out=0, state RUN, stall_cycles unchanged.
REQ-032 Load instr_in=16'h0000 -> halt_out=1, pc_en=0 in capture cycle and after; later instr_in=16'h4123 ignored; flush -> halt_out=0, NOP, pc_en=1.
REQ-033 rst asserted while HALTED with stall=1 -> next cycle reset values per REQ-023; stall_cycles=0.
